// File: rtl/xm_test_pkg.sv
// Shared types for the Wishbone memory exerciser: operation modes, FSM states
// and byte-lane helpers.
package xm_test_pkg;

  typedef enum logic [1:0] {
    READ1       = 2'd0,
    WRITE1      = 2'd1,
    FILL        = 2'd2,
    FILL_VERIFY = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    WR_GAP = 3'd2,
    RD     = 3'd3,
    RD_GAP = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SEL_W  = DATA_W / 8;

  // Byte-lane count for an arbitrary data width.
  function automatic int unsigned sel_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Counts consecutive cycles of an unacknowledged bus strobe and flags when the
// programmed limit is reached.
module wb_timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic arst_ni,
  input  logic run_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // Counter value equals the number of strobe cycles already spent waiting.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      cnt_q <= '0;
    end else if (clr_i || !run_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // An ack in the same cycle suppresses expiry so the ack wins.
  assign expired_o = run_i && !clr_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_mem_exerciser.sv
// Wishbone classic master that reads, writes, fills or fill-verifies a memory
// window, tracking mismatches and bus timeouts.
module wb_mem_exerciser
  import xm_test_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADR_W   = 16,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic [ADR_W-1:0]      base_adr_i,
  input  logic [CNT_W-1:0]      count_i,
  input  logic [DATA_W-1:0]     pattern_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timeout_o,
  output logic [CNT_W-1:0]      err_cnt_o,
  output logic [ADR_W-1:0]      fail_adr_o,
  output logic [DATA_W-1:0]     last_dat_o,
  input  logic                  ack_i,
  input  logic [DATA_W-1:0]     dat_i,
  output logic                  we_o,
  output logic                  stb_o,
  output logic                  cyc_o,
  output logic [DATA_W/8-1:0]   sel_o,
  output logic [ADR_W-1:0]      adr_o,
  output logic [DATA_W-1:0]     dat_o
);

  localparam int unsigned      SEL_N    = sel_width(DATA_W);
  localparam logic [ADR_W-1:0] ADR_STEP = ADR_W'(SEL_N);
  localparam logic [ADR_W-1:0] ADR_MASK = ~ADR_W'(SEL_N - 1);

  state_t            state_q;
  mode_t             mode_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  k_q;
  logic [ADR_W-1:0]  base_q;
  logic [DATA_W-1:0] exp_q;

  mode_t             start_mode_c;
  logic [CNT_W-1:0]  start_cnt_c;
  logic [ADR_W-1:0]  start_adr_c;
  logic              tmo_run_c;
  logic              tmo_expired_c;
  logic              mismatch_c;

  assign start_mode_c = mode_t'(mode_i);
  assign start_adr_c  = base_adr_i & ADR_MASK;
  assign tmo_run_c    = (state_q == WR) || (state_q == RD);
  assign mismatch_c   = (mode_q == FILL_VERIFY) && (dat_i != exp_q);

  // Single-word modes ignore the requested count.
  always_comb begin
    start_cnt_c = count_i;
    if (start_mode_c == READ1 || start_mode_c == WRITE1) begin
      start_cnt_c = CNT_W'(1);
    end
  end

  wb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .run_i     (tmo_run_c),
    .clr_i     (ack_i),
    .expired_o (tmo_expired_c)
  );

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q    <= IDLE;
      mode_q     <= READ1;
      cnt_q      <= '0;
      k_q        <= '0;
      base_q     <= '0;
      exp_q      <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      timeout_o  <= 1'b0;
      err_cnt_o  <= '0;
      fail_adr_o <= '0;
      last_dat_o <= '0;
      we_o       <= 1'b0;
      stb_o      <= 1'b0;
      cyc_o      <= 1'b0;
      sel_o      <= '0;
      adr_o      <= '0;
      dat_o      <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            mode_q     <= start_mode_c;
            cnt_q      <= start_cnt_c;
            k_q        <= '0;
            base_q     <= start_adr_c;
            exp_q      <= pattern_i;
            busy_o     <= 1'b1;
            timeout_o  <= 1'b0;
            err_cnt_o  <= '0;
            fail_adr_o <= '0;
            adr_o      <= start_adr_c;
            dat_o      <= pattern_i;
            if (start_cnt_c == '0) begin
              state_q <= DONE;
            end else begin
              cyc_o   <= 1'b1;
              stb_o   <= 1'b1;
              sel_o   <= '1;
              we_o    <= (start_mode_c != READ1);
              state_q <= (start_mode_c == READ1) ? RD : WR;
            end
          end
        end

        WR: begin
          if (ack_i) begin
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
            k_q     <= k_q + CNT_W'(1);
            adr_o   <= adr_o + ADR_STEP;
            dat_o   <= dat_o + DATA_W'(1);
            state_q <= WR_GAP;
          end else if (tmo_expired_c) begin
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            we_o      <= 1'b0;
            timeout_o <= 1'b1;
            if (err_cnt_o == '0) fail_adr_o <= adr_o;
            state_q   <= DONE;
          end
        end

        WR_GAP: begin
          if (k_q < cnt_q) begin
            cyc_o   <= 1'b1;
            stb_o   <= 1'b1;
            state_q <= WR;
          end else if (mode_q == FILL_VERIFY) begin
            // Readback sweep restarts from the window base.
            k_q     <= '0;
            adr_o   <= base_q;
            we_o    <= 1'b0;
            cyc_o   <= 1'b1;
            stb_o   <= 1'b1;
            state_q <= RD;
          end else begin
            we_o    <= 1'b0;
            state_q <= DONE;
          end
        end

        RD: begin
          if (ack_i) begin
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            last_dat_o <= dat_i;
            k_q        <= k_q + CNT_W'(1);
            adr_o      <= adr_o + ADR_STEP;
            exp_q      <= exp_q + DATA_W'(1);
            if (mismatch_c) begin
              if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_W'(1);
              if (err_cnt_o == '0) fail_adr_o <= adr_o;
            end
            state_q <= RD_GAP;
          end else if (tmo_expired_c) begin
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            timeout_o <= 1'b1;
            if (err_cnt_o == '0) fail_adr_o <= adr_o;
            state_q   <= DONE;
          end
        end

        RD_GAP: begin
          if (k_q < cnt_q) begin
            cyc_o   <= 1'b1;
            stb_o   <= 1'b1;
            state_q <= RD;
          end else begin
            state_q <= DONE;
          end
        end

        DONE: begin
          done_o  <= 1'b1;
          busy_o  <= 1'b0;
          we_o    <= 1'b0;
          sel_o   <= '0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_exerciser.sv
// Directed bench for wb_mem_exerciser against a latency-programmable memory
// slave with fault injection on reads.
module tb_wb_mem_exerciser;

  logic        clk_i = 1'b0;
  logic        arst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic [15:0] base_adr_i = '0;
  logic [15:0] count_i = '0;
  logic [15:0] pattern_i = '0;
  logic        busy_o, done_o, timeout_o;
  logic [15:0] err_cnt_o, fail_adr_o, last_dat_o;
  logic        ack_i;
  logic [15:0] dat_i;
  logic        we_o, stb_o, cyc_o;
  logic [1:0]  sel_o;
  logic [15:0] adr_o, dat_o;

  int errors = 0;
  int checks = 0;

  int          lat = 0;
  logic        no_ack = 1'b0;
  logic        corrupt_en = 1'b0;
  logic        corrupt_all = 1'b0;
  logic [15:0] corrupt_adr = '0;
  int          wcnt;
  logic [15:0] mem [0:255];
  int          done_total = 0;

  always #5 clk_i = ~clk_i;

  wb_mem_exerciser #(
    .DATA_W (16), .ADR_W (16), .CNT_W (16), .TIMEOUT (15)
  ) dut (
    .clk_i (clk_i), .arst_ni (arst_ni), .start_i (start_i), .mode_i (mode_i),
    .base_adr_i (base_adr_i), .count_i (count_i), .pattern_i (pattern_i),
    .busy_o (busy_o), .done_o (done_o), .timeout_o (timeout_o),
    .err_cnt_o (err_cnt_o), .fail_adr_o (fail_adr_o), .last_dat_o (last_dat_o),
    .ack_i (ack_i), .dat_i (dat_i), .we_o (we_o), .stb_o (stb_o), .cyc_o (cyc_o),
    .sel_o (sel_o), .adr_o (adr_o), .dat_o (dat_o)
  );

  // Slave model: acks after lat wait cycles, optionally corrupting reads.
  assign ack_i = cyc_o && stb_o && !no_ack && (wcnt == lat);
  assign dat_i = (!we_o && (corrupt_all || (corrupt_en && adr_o == corrupt_adr)))
                 ? 16'h0000 : mem[adr_o[8:1]];

  always @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wcnt <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
    end else begin
      wcnt <= (stb_o && !ack_i) ? wcnt + 1 : 0;
      if (cyc_o && stb_o && we_o && ack_i) mem[adr_o[8:1]] <= dat_o;
    end
  end

  always @(negedge clk_i) if (done_o) done_total++;

  // Launch one operation and wait (bounded) for done; reports edge count to done.
  task automatic run_op(input logic [1:0] mode, input logic [15:0] base,
                        input logic [15:0] cnt, input logic [15:0] pat,
                        output int n, output int stb_hi, output bit cyc_seen);
    mode_i = mode; base_adr_i = base; count_i = cnt; pattern_i = pat;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n = 0; stb_hi = stb_o ? 1 : 0; cyc_seen = cyc_o;
    while (!done_o && n < 300) begin
      @(posedge clk_i); #1;
      n++;
      if (stb_o) stb_hi++;
      if (cyc_o) cyc_seen = 1'b1;
    end
    checks++;
    if (!done_o) begin
      errors++;
      $display("FAIL done_wait: done_o not seen within %0d cycles", n);
    end
    @(posedge clk_i); #1;
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL done_width: done_o=%b busy_o=%b after pulse, required 0 0", done_o, busy_o);
    end
  endtask

  task automatic test_reset();
    arst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({busy_o, done_o, timeout_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_status: busy/done/timeout=%b required 000", {busy_o, done_o, timeout_o});
    end
    checks++;
    if (err_cnt_o !== 16'h0 || fail_adr_o !== 16'h0 || last_dat_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_results: err=%h fail=%h last=%h required 0 0 0", err_cnt_o, fail_adr_o, last_dat_o);
    end
    checks++;
    if ({cyc_o, stb_o, we_o, sel_o} !== 5'b0 || adr_o !== 16'h0 || dat_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_bus: cyc/stb/we/sel=%b adr=%h dat=%h required all 0", {cyc_o, stb_o, we_o, sel_o}, adr_o, dat_o);
    end
    arst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_write_read();
    int n, sh, d0;
    bit cs;
    d0 = done_total;
    run_op(2'd1, 16'h0010, 16'd5, 16'hBEEF, n, sh, cs);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL write1_latency: %0d cycles required 3", n); end
    checks++;
    if (mem[8] !== 16'hBEEF || mem[9] !== 16'h0000) begin
      errors++; $display("FAIL write1_mem: mem[10]=%h mem[12]=%h required beef 0000", mem[8], mem[9]);
    end
    checks++;
    if (done_total - d0 !== 1) begin errors++; $display("FAIL write1_done: %0d pulses required 1", done_total - d0); end
    d0 = done_total;
    run_op(2'd0, 16'h0011, 16'd0, 16'h0000, n, sh, cs);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL read1_latency: %0d cycles required 3", n); end
    checks++;
    if (last_dat_o !== 16'hBEEF || err_cnt_o !== 16'h0) begin
      errors++; $display("FAIL read1_data: last=%h err=%h required beef 0", last_dat_o, err_cnt_o);
    end
    checks++;
    if (done_total - d0 !== 1) begin errors++; $display("FAIL read1_done: %0d pulses required 1", done_total - d0); end
  endtask

  task automatic test_fill_verify_wrap();
    int n, sh;
    bit cs;
    run_op(2'd3, 16'h0000, 16'd8, 16'hFFFC, n, sh, cs);
    checks++;
    if (n !== 33) begin errors++; $display("FAIL fv_latency: %0d cycles required 33", n); end
    checks++;
    if (mem[0] !== 16'hFFFC || mem[3] !== 16'hFFFF || mem[4] !== 16'h0000 || mem[7] !== 16'h0003) begin
      errors++; $display("FAIL fv_mem: %h %h %h %h required fffc ffff 0000 0003", mem[0], mem[3], mem[4], mem[7]);
    end
    checks++;
    if (err_cnt_o !== 16'h0 || last_dat_o !== 16'h0003 || timeout_o !== 1'b0) begin
      errors++; $display("FAIL fv_result: err=%h last=%h tmo=%b required 0 0003 0", err_cnt_o, last_dat_o, timeout_o);
    end
  endtask

  task automatic test_mismatch();
    int n, sh;
    bit cs;
    corrupt_en = 1'b1; corrupt_adr = 16'h0004;
    run_op(2'd3, 16'h0000, 16'd4, 16'h1000, n, sh, cs);
    corrupt_en = 1'b0;
    checks++;
    if (err_cnt_o !== 16'd1 || fail_adr_o !== 16'h0004 || last_dat_o !== 16'h1003) begin
      errors++; $display("FAIL single_mismatch: err=%h fail=%h last=%h required 0001 0004 1003", err_cnt_o, fail_adr_o, last_dat_o);
    end
    corrupt_all = 1'b1;
    run_op(2'd3, 16'h0021, 16'd3, 16'h0001, n, sh, cs);
    corrupt_all = 1'b0;
    checks++;
    if (err_cnt_o !== 16'd3 || fail_adr_o !== 16'h0020 || last_dat_o !== 16'h0000) begin
      errors++; $display("FAIL all_mismatch: err=%h fail=%h last=%h required 0003 0020 0000", err_cnt_o, fail_adr_o, last_dat_o);
    end
  endtask

  task automatic test_latency();
    int n, sh;
    bit cs;
    lat = 2;
    run_op(2'd2, 16'h0060, 16'd3, 16'h7FFE, n, sh, cs);
    checks++;
    if (n !== 13) begin errors++; $display("FAIL lat2_cycles: %0d cycles required 13", n); end
    checks++;
    if (mem[8'h30] !== 16'h7FFE || mem[8'h32] !== 16'h8000) begin
      errors++; $display("FAIL lat2_mem: %h %h required 7ffe 8000", mem[8'h30], mem[8'h32]);
    end
    lat = 14;
    run_op(2'd1, 16'h0070, 16'd1, 16'h1234, n, sh, cs);
    lat = 0;
    checks++;
    if (n !== 17 || timeout_o !== 1'b0 || mem[8'h38] !== 16'h1234) begin
      errors++; $display("FAIL ack_beats_timeout: cycles=%0d tmo=%b mem=%h required 17 0 1234", n, timeout_o, mem[8'h38]);
    end
  endtask

  task automatic test_count_zero();
    int n, sh, d0;
    bit cs;
    d0 = done_total;
    run_op(2'd2, 16'h0050, 16'd0, 16'h4444, n, sh, cs);
    checks++;
    if (n !== 1 || cs !== 1'b0) begin
      errors++; $display("FAIL count_zero: cycles=%0d cyc_seen=%b required 1 0", n, cs);
    end
    checks++;
    if (done_total - d0 !== 1) begin errors++; $display("FAIL count_zero_done: %0d pulses required 1", done_total - d0); end
  endtask

  task automatic test_timeout();
    int n, sh;
    bit cs;
    no_ack = 1'b1;
    run_op(2'd2, 16'h0040, 16'd2, 16'h9999, n, sh, cs);
    no_ack = 1'b0;
    checks++;
    if (sh !== 15 || n !== 16) begin
      errors++; $display("FAIL timeout_cycles: stb_high=%0d done_at=%0d required 15 16", sh, n);
    end
    checks++;
    if (timeout_o !== 1'b1 || fail_adr_o !== 16'h0040 || err_cnt_o !== 16'h0) begin
      errors++; $display("FAIL timeout_result: tmo=%b fail=%h err=%h required 1 0040 0", timeout_o, fail_adr_o, err_cnt_o);
    end
    run_op(2'd1, 16'h0090, 16'd1, 16'h0A0A, n, sh, cs);
    checks++;
    if (timeout_o !== 1'b0 || fail_adr_o !== 16'h0000) begin
      errors++; $display("FAIL timeout_clear: tmo=%b fail=%h required 0 0000", timeout_o, fail_adr_o);
    end
  endtask

  task automatic test_reset_mid();
    no_ack = 1'b1;
    mode_i = 2'd2; base_adr_i = 16'h0080; count_i = 16'd4; pattern_i = 16'h5555;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    mode_i = 2'd0; base_adr_i = 16'h00F0; count_i = 16'd1;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || stb_o !== 1'b1 || we_o !== 1'b1 || adr_o !== 16'h0080) begin
      errors++; $display("FAIL start_while_busy: busy=%b stb=%b we=%b adr=%h required 1 1 1 0080", busy_o, stb_o, we_o, adr_o);
    end
    #2 arst_ni = 1'b0;
    #1;
    checks++;
    if (cyc_o !== 1'b0 || stb_o !== 1'b0) begin
      errors++; $display("FAIL async_reset_bus: cyc=%b stb=%b required 0 0", cyc_o, stb_o);
    end
    #3 arst_ni = 1'b1;
    no_ack = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (busy_o !== 1'b0 || cyc_o !== 1'b0 || done_o !== 1'b0 || timeout_o !== 1'b0) begin
      errors++; $display("FAIL reset_to_idle: busy=%b cyc=%b done=%b tmo=%b required 0 0 0 0", busy_o, cyc_o, done_o, timeout_o);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_fill_verify_wrap();
    test_mismatch();
    test_latency();
    test_count_zero();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_mem_exerciser.md
# wb_mem_exerciser

Parametrised Wishbone classic bus master that exercises a memory slave. It performs a single read, a single write, a pattern fill, or a fill-then-verify sweep over a programmable address window, and counts mismatches and bus timeouts. It sits between front-panel or debug control logic and any `mem_wishbone`-compatible slave, and its result outputs feed the display driver. It is the generalised successor to the board-level memory tester: width, window, pattern and timeout are configurable, and it adds error accounting.

## Interface
Parameters:
- `DATA_W`, 16, data bus width; must be a multiple of 8.
- `ADR_W`, 16, byte-address width.
- `CNT_W`, 16, width of the word count and error counter.
- `TIMEOUT`, 255, maximum cycles to wait for `ack_i` before a transfer is aborted; must be ≥1.

Ports:
- `clk_i` in 1: system clock; all logic is on the rising edge.
- `arst_ni` in 1: asynchronous, active-low reset.
- `start_i` in 1: starts an operation when the block is idle; sampled once per cycle.
- `mode_i` in 2: operation select. 0 = READ1, 1 = WRITE1, 2 = FILL, 3 = FILL_VERIFY.
- `base_adr_i` in ADR_W: first byte address; low log2(DATA_W/8) bits are ignored.
- `count_i` in CNT_W: number of words to access; READ1 and WRITE1 use 1 regardless of this value.
- `pattern_i` in DATA_W: seed value; word k is written or expected as `pattern_i + k`, modulo 2^DATA_W.
- `busy_o` out 1: high while an operation is in progress.
- `done_o` out 1: single-cycle pulse when an operation ends.
- `timeout_o` out 1: set if the last operation aborted on a timeout.
- `err_cnt_o` out CNT_W: mismatches in the last operation; saturates at all-ones.
- `fail_adr_o` out ADR_W: address of the first mismatch or timeout.
- `last_dat_o` out DATA_W: last word read from the bus.
- Wishbone master ports: `ack_i` in 1, `dat_i` in DATA_W, `we_o` out 1, `stb_o` out 1, `cyc_o` out 1, `sel_o` out DATA_W/8, `adr_o` out ADR_W, `dat_o` out DATA_W.

## Operation
- States: IDLE, WR, WR_GAP, RD, RD_GAP, DONE.
- IDLE:
  - `start_i` = 1 latches `mode_i`, `base_adr_i`, `count_i` and `pattern_i`.
  - It clears `err_cnt_o`, `timeout_o` and `fail_adr_o`, and sets the word index k to 0.
  - Next state: WR for modes 1–3, RD for mode 0.
  - If the effective count is 0, the block goes to DONE with no bus cycle.
- WR:
  - `cyc_o` = `stb_o` = `we_o` = 1, `sel_o` all ones.
  - `adr_o` = base + k·(DATA_W/8); `dat_o` = pattern + k.
  - On `ack_i`, k increments and the block moves to WR_GAP.
- WR_GAP:
  - `cyc_o` and `stb_o` are 0 for exactly one cycle.
  - Next state when k < count: WR.
  - Next state when writes are finished: RD (with k reset to 0) for FILL_VERIFY; DONE otherwise.
- RD:
  - Same bus signals as WR, but with `we_o` = 0.
  - On `ack_i`, `dat_i` is captured into `last_dat_o`.
  - In FILL_VERIFY mode, if `dat_i` ≠ pattern + k, `err_cnt_o` increments (saturating). On the first mismatch only, `fail_adr_o` takes the current `adr_o`.
  - Next state: RD_GAP.
- RD_GAP: as WR_GAP, returning to RD while k < count, else DONE.
- DONE: `done_o` = 1 for one cycle, then the block returns to IDLE.
- Timeout:
  - A wait counter runs in WR and RD and is cleared on every `ack_i`.
  - When it reaches TIMEOUT without an ack, the bus signals drop and `timeout_o` is set.
  - `fail_adr_o` takes the current `adr_o` if no mismatch has been recorded yet. The block goes to DONE.
- `start_i` is ignored unless the block is in IDLE.
- Address arithmetic wraps modulo 2^ADR_W; pattern arithmetic wraps modulo 2^DATA_W.

## Timing
- Reset values:
  - All outputs are 0, except `sel_o`, which is also 0.
  - The state is IDLE.
- Reset is asynchronous. Asserting it mid-transfer drops `cyc_o` and `stb_o` immediately, without waiting for a clock edge.
- `adr_o`, `dat_o`, `we_o` and `sel_o` are registered, and stay stable for the whole time `stb_o` is high.
- `busy_o` rises the cycle after `start_i` is accepted. It falls in the same cycle that `done_o` pulses.
- Transfer timing:
  - A transfer takes at least 2 cycles: the strobe cycle plus the gap cycle, with `ack_i` arriving in the first strobe cycle.
  - With an ack latency of L cycles, a transfer takes L+2 cycles.
- `ack_i` arriving in a gap cycle or in IDLE is ignored.
- If `ack_i` and the timeout coincide in the same cycle, the ack wins.
- Result outputs hold their values until the next accepted `start_i`.

## Structure
- The shared package `xm_test_pkg` holds:
  - the `mode_t` enum (READ1, WRITE1, FILL, FILL_VERIFY);
  - the `state_t` enum;
  - localparam `SEL_W = DATA_W/8`.
- One sub-module, `wb_timeout_counter`, parametrised by TIMEOUT. Ports: `clk_i`, `arst_ni`, `run_i`, `clr_i`, `expired_o`.
- Top-level glue instantiates this block in place of the old tester, and drives `last_dat_o` and `err_cnt_o` onto the display through a mux.

## Test plan
- WRITE1 at 0x0010 with pattern 0xBEEF, then READ1 at 0x0010 → `last_dat_o` = 0xBEEF, `err_cnt_o` = 0, `done_o` pulses once per operation.
- FILL_VERIFY, base 0x0000, count 8, pattern 0xFFFC, clean memory → writes 0xFFFC, 0xFFFD, …, 0x0003 (wraps), reads them back; `err_cnt_o` = 0.
- FILL_VERIFY, count 4, with the slave model forcing the read at 0x0004 to return 0x0000 → `err_cnt_o` = 1, `fail_adr_o` = 0x0004.
- Slave never acks, TIMEOUT = 15 → `stb_o` drops after 15 cycles, `timeout_o` = 1, `fail_adr_o` = base, `done_o` pulses.
- Count 0 in FILL mode → `done_o` pulses 2 cycles after start, with no `cyc_o` activity.
- `arst_ni` asserted while `stb_o` = 1, and `start_i` pulsed while `busy_o` = 1 → bus signals go to 0 asynchronously, the block is in IDLE, and the second start has no effect.
